// File: rtl/mem_bus_master_if.sv
// Request/response handshake between the interpreter core and the memory bus master.
// The core drives through the master modport; mem_bus_master answers through the slave modport.
interface mem_bus_master_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_sel;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_sel, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_sel, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_bus_master.sv
// Sequences CEb/OEb/WEb and the shared tristate data bus of the 16x8 RAM and ROM chips,
// turning one accepted request into a setup/strobe/hold cycle and a single response pulse.
module mem_bus_master #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic              clk,
    input  logic              rstb,
    mem_bus_master_if.slave   bus,
    output logic [ADDR_W-1:0] mem_addr,
    inout  wire  [DATA_W-1:0] mem_data,
    output logic              ram_CEb,
    output logic              ram_WEb,
    output logic              ram_OEb,
    output logic              rom_CEb
);
    localparam int MAX_CYC = (SETUP_CYC > STROBE_CYC)
                           ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                           : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
    localparam int CNT_W = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              wr_q;
    logic              sel_q;
    logic [DATA_W-1:0] wdata_q;
    logic              drive_en;

    // The master only ever drives the bus for the whole body of a RAM write.
    assign mem_data = drive_en ? wdata_q : {DATA_W{1'bz}};

    // One down-counter is reloaded on every phase entry; a write to the ROM skips the chip cycle.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state         <= IDLE;
            cnt           <= '0;
            wr_q          <= 1'b0;
            sel_q         <= 1'b0;
            wdata_q       <= '0;
            drive_en      <= 1'b0;
            mem_addr      <= '0;
            ram_CEb       <= 1'b1;
            ram_WEb       <= 1'b1;
            ram_OEb       <= 1'b1;
            rom_CEb       <= 1'b1;
            bus.req_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
        end else begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    bus.req_ready <= 1'b1;
                    if (bus.req_valid && bus.req_ready) begin
                        bus.req_ready <= 1'b0;
                        mem_addr      <= bus.req_addr;
                        wr_q          <= bus.req_write;
                        sel_q         <= bus.req_sel;
                        wdata_q       <= bus.req_wdata;
                        if (bus.req_write && bus.req_sel) begin
                            state         <= RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                        end else begin
                            state    <= SETUP;
                            cnt      <= SETUP_LD;
                            ram_CEb  <= bus.req_sel;
                            rom_CEb  <= !bus.req_sel;
                            drive_en <= bus.req_write;
                        end
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        state <= STROBE;
                        cnt   <= STROBE_LD;
                        // The ROM has no OE pin, so a ROM read simply keeps CEb low.
                        if (!sel_q) begin
                            ram_OEb <= wr_q;
                            ram_WEb <= !wr_q;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STROBE: begin
                    if (cnt == '0) begin
                        state   <= HOLD;
                        cnt     <= HOLD_LD;
                        ram_OEb <= 1'b1;
                        ram_WEb <= 1'b1;
                        if (!wr_q) begin
                            bus.rsp_rdata <= mem_data;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state         <= RESP;
                        ram_CEb       <= 1'b1;
                        rom_CEb       <= 1'b1;
                        drive_en      <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
